// File: rtl/sample_uart_tx_pkg.sv
// sample_uart_tx_pkg
// Shared definitions for the sample UART transmitter slice.
//   txState_e       : serializer states, IDLE through STOP
//   UART_IDLE_LEVEL : level the TX line rests at between frames
// The PARITY state is only entered in builds that define
// SAMPLE_UART_TX_PARITY_EN.
package sample_uart_tx_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      START,
      DATA,
      PARITY,
      STOP
   } txState_e;

   localparam logic UART_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/fifo.sv
// fifo
// Sample FIFO with a registered read port: the word popped by rdEn_i
// shows up on rdData_o in the following cycle.
// Ports:
//   clk_i, reset_i : clock and synchronous active-high reset
//   wrEn_i/wrData_i: push a sample (dropped when full)
//   rdEn_i         : pop the oldest sample (ignored when empty)
//   rdData_o       : registered read data
//   empty_o/full_o : occupancy flags
//   fill_o         : current sample count, 0..SIZE
//   overflow_o     : sticky, set when a write is dropped
// SIZE must be a power of two so the pointers wrap naturally.
module fifo
   import sample_uart_tx_pkg::*;
#(
   parameter int BITS = 8,
   parameter int SIZE = 1024
) (
   input  logic                    clk_i,
   input  logic                    reset_i,
   input  logic                    wrEn_i,
   input  logic [BITS-1:0]         wrData_i,
   input  logic                    rdEn_i,
   output logic [BITS-1:0]         rdData_o,
   output logic                    empty_o,
   output logic                    full_o,
   output logic [$clog2(SIZE):0]   fill_o,
   output logic                    overflow_o
);

   localparam int AW = $clog2(SIZE);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_COUNT = CW'(SIZE);

   logic [BITS-1:0] mem [SIZE];
   logic [AW-1:0]   wrPtr_q;
   logic [AW-1:0]   rdPtr_q;
   logic [CW-1:0]   count_q;
   logic [BITS-1:0] rdData_q;
   logic            overflow_q;
   logic            doWrite;
   logic            doRead;

   // A write into a full FIFO is lost even if a read frees a slot in the
   // same cycle, so acceptance only looks at the current count.
   always_comb begin
      empty_o = (count_q == '0);
      full_o  = (count_q == FULL_COUNT);
      doWrite = wrEn_i && !full_o;
      doRead  = rdEn_i && !empty_o;
   end

   // Pointers, count, registered read data and the sticky overflow flag.
   // Simultaneous accepted write and read leave the count unchanged.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         wrPtr_q    <= '0;
         rdPtr_q    <= '0;
         count_q    <= '0;
         rdData_q   <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (doWrite) begin
            wrPtr_q <= wrPtr_q + AW'(1);
         end
         if (doRead) begin
            rdPtr_q  <= rdPtr_q + AW'(1);
            rdData_q <= mem[rdPtr_q];
         end
         if (doWrite && !doRead) begin
            count_q <= count_q + CW'(1);
         end else if (doRead && !doWrite) begin
            count_q <= count_q - CW'(1);
         end
         if (wrEn_i && full_o) begin
            overflow_q <= 1'b1;
         end
      end
   end

   // Storage array; it carries no reset because stale entries are never
   // visible once the pointers are cleared.
   always_ff @(posedge clk_i) begin
      if (doWrite) begin
         mem[wrPtr_q] <= wrData_i;
      end
   end

   assign rdData_o   = rdData_q;
   assign fill_o     = count_q;
   assign overflow_o = overflow_q;

endmodule

// File: rtl/sample_uart_tx.sv
// sample_uart_tx
// Buffered UART transmitter returning audio samples to the host. Samples
// are queued in a FIFO and sent as 8N1 frames, or 8E1 when the build
// defines SAMPLE_UART_TX_PARITY_EN. A new frame only starts while cts is
// high; a frame already started always completes.
// Ports:
//   clk, reset          : clock and synchronous active-high reset
//   wr_en, wr_data      : sample write strobe and data
//   cts                 : host allows a new frame when high
//   tx                  : UART line, idle high
//   busy                : a frame is in progress (LOAD through STOP)
//   fifo_empty/full     : FIFO occupancy flags
//   fill                : FIFO sample count
//   overflow            : sticky, set when a write was dropped
module sample_uart_tx
   import sample_uart_tx_pkg::*;
#(
   parameter int CLOCK_DIVIDE = 104,
   parameter int BITS         = 8,
   parameter int FIFO_SIZE    = 1024
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         wr_en,
   input  logic [BITS-1:0]              wr_data,
   input  logic                         cts,
   output logic                         tx,
   output logic                         busy,
   output logic                         fifo_empty,
   output logic                         fifo_full,
   output logic [$clog2(FIFO_SIZE):0]   fill,
   output logic                         overflow
);

   localparam int TW = ($clog2(CLOCK_DIVIDE) < 1) ? 1 : $clog2(CLOCK_DIVIDE);
   localparam int IW = ($clog2(BITS) < 1) ? 1 : $clog2(BITS);
   localparam logic [TW-1:0] TIMER_RELOAD = TW'(CLOCK_DIVIDE - 1);
   localparam logic [IW-1:0] LAST_BIT     = IW'(BITS - 1);

   txState_e        state_q, state_d;
   logic [TW-1:0]   timer_q, timer_d;
   logic [IW-1:0]   bitIdx_q, bitIdx_d;
   logic [BITS-1:0] shift_q, shift_d;
`ifdef SAMPLE_UART_TX_PARITY_EN
   logic            parity_q, parity_d;
`endif
   logic            rdEn;
   logic [BITS-1:0] rdData;

   fifo #(
      .BITS (BITS),
      .SIZE (FIFO_SIZE)
   ) sampleFifo (
      .clk_i      (clk),
      .reset_i    (reset),
      .wrEn_i     (wr_en),
      .wrData_i   (wr_data),
      .rdEn_i     (rdEn),
      .rdData_o   (rdData),
      .empty_o    (fifo_empty),
      .full_o     (fifo_full),
      .fill_o     (fill),
      .overflow_o (overflow)
   );

   // Serializer state, bit timer, bit index and shift register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         timer_q  <= '0;
         bitIdx_q <= '0;
         shift_q  <= '0;
`ifdef SAMPLE_UART_TX_PARITY_EN
         parity_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         timer_q  <= timer_d;
         bitIdx_q <= bitIdx_d;
         shift_q  <= shift_d;
`ifdef SAMPLE_UART_TX_PARITY_EN
         parity_q <= parity_d;
`endif
      end
   end

   // Next-state logic. The FIFO read is issued from IDLE so the registered
   // read data is valid in LOAD, where it is captured. Every state that
   // drives a bit holds it for CLOCK_DIVIDE clocks: the timer is reloaded
   // on entry and the state advances when it reaches zero.
   always_comb begin
      state_d  = state_q;
      timer_d  = timer_q;
      bitIdx_d = bitIdx_q;
      shift_d  = shift_q;
      rdEn     = 1'b0;
`ifdef SAMPLE_UART_TX_PARITY_EN
      parity_d = parity_q;
`endif
      case (state_q)
         IDLE: begin
            if (!fifo_empty && cts) begin
               rdEn    = 1'b1;
               state_d = LOAD;
            end
         end
         LOAD: begin
            shift_d = rdData;
            timer_d = TIMER_RELOAD;
            state_d = START;
`ifdef SAMPLE_UART_TX_PARITY_EN
            parity_d = ^rdData;
`endif
         end
         START: begin
            if (timer_q == '0) begin
               timer_d  = TIMER_RELOAD;
               bitIdx_d = '0;
               state_d  = DATA;
            end else begin
               timer_d = timer_q - TW'(1);
            end
         end
         DATA: begin
            if (timer_q == '0) begin
               timer_d = TIMER_RELOAD;
               if (bitIdx_q == LAST_BIT) begin
`ifdef SAMPLE_UART_TX_PARITY_EN
                  state_d = PARITY;
`else
                  state_d = STOP;
`endif
               end else begin
                  bitIdx_d = bitIdx_q + IW'(1);
                  shift_d  = shift_q >> 1;
               end
            end else begin
               timer_d = timer_q - TW'(1);
            end
         end
`ifdef SAMPLE_UART_TX_PARITY_EN
         PARITY: begin
            if (timer_q == '0) begin
               timer_d = TIMER_RELOAD;
               state_d = STOP;
            end else begin
               timer_d = timer_q - TW'(1);
            end
         end
`endif
         STOP: begin
            if (timer_q == '0) begin
               state_d = IDLE;
            end else begin
               timer_d = timer_q - TW'(1);
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Line level decoded from the current state; the LSB of the shift
   // register is always the data bit being sent.
   always_comb begin
      busy = (state_q != IDLE);
      case (state_q)
         START:   tx = ~UART_IDLE_LEVEL;
         DATA:    tx = shift_q[0];
`ifdef SAMPLE_UART_TX_PARITY_EN
         PARITY:  tx = parity_q;
`endif
         default: tx = UART_IDLE_LEVEL;
      endcase
   end

endmodule

// File: tb/tb_sample_uart_tx.sv
// tb_sample_uart_tx
// Self-checking bench for sample_uart_tx with CLOCK_DIVIDE=4 and
// FIFO_SIZE=4. A queue-based model predicts the line and FIFO status every
// cycle from frame timing; directed scenarios pin it with literal values,
// then randomized writes and cts toggling stress it. Parity expectations
// follow SAMPLE_UART_TX_PARITY_EN when the bench is built with it.
module tb_sample_uart_tx;

   localparam int CD    = 4;
   localparam int NBITS = 8;
   localparam int DEPTH = 4;
`ifdef SAMPLE_UART_TX_PARITY_EN
   localparam int FRAME_BITS = NBITS + 3;
`else
   localparam int FRAME_BITS = NBITS + 2;
`endif
   localparam int FRAME_LEN = FRAME_BITS * CD;

   logic       clk = 1'b0;
   logic       reset;
   logic       wrEn;
   logic [7:0] wrData;
   logic       ctsIn;
   logic       tx;
   logic       busy;
   logic       fifoEmpty;
   logic       fifoFull;
   logic [2:0] fill;
   logic       overflow;

   int checkCount = 0;
   int passCount  = 0;
   int cyc        = 0;
   bit compareOn  = 1'b1;

   byte unsigned modelQ[$];
   bit           modelOvf    = 1'b0;
   bit           modelActive = 1'b0;
   int           modelT      = 0;
   logic [7:0]   modelByte   = '0;

   sample_uart_tx #(
      .CLOCK_DIVIDE (CD),
      .BITS         (NBITS),
      .FIFO_SIZE    (DEPTH)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .wr_en      (wrEn),
      .wr_data    (wrData),
      .cts        (ctsIn),
      .tx         (tx),
      .busy       (busy),
      .fifo_empty (fifoEmpty),
      .fifo_full  (fifoFull),
      .fill       (fill),
      .overflow   (overflow)
   );

   always #5 clk = ~clk;

   // Line level the model expects: modelT counts cycles since the frame's
   // LOAD cycle, so cycle t>=1 lies in frame bit (t-1)/CD.
   function automatic logic expectedTx();
      int k;
      if (!modelActive || modelT == 0) return 1'b1;
      k = (modelT - 1) / CD;
      if (k == 0) return 1'b0;
      if (k <= NBITS) return modelByte[k-1];
`ifdef SAMPLE_UART_TX_PARITY_EN
      if (k == NBITS + 1) return ^modelByte;
`endif
      return 1'b1;
   endfunction

   // Model update on each rising edge using the inputs held over the cycle.
   // An idle cycle with queued data and cts high pops the oldest sample and
   // starts a frame; a frame lasts one LOAD cycle plus FRAME_LEN bit clocks.
   always @(posedge clk) begin
      bit startRead;
      bit wasFull;
      cyc++;
      if (reset) begin
         modelQ.delete();
         modelOvf    = 1'b0;
         modelActive = 1'b0;
         modelT      = 0;
      end else begin
         startRead = !modelActive && (modelQ.size() > 0) && ctsIn;
         wasFull   = (modelQ.size() == DEPTH);
         if (modelActive) begin
            if (modelT == FRAME_LEN) modelActive = 1'b0;
            else modelT++;
         end
         if (startRead) begin
            modelByte   = modelQ.pop_front();
            modelActive = 1'b1;
            modelT      = 0;
         end
         if (wrEn) begin
            if (wasFull) modelOvf = 1'b1;
            else modelQ.push_back(wrData);
         end
      end
   end

   // Cycle-by-cycle comparison of every output against the model.
   always @(negedge clk) begin
      logic expTx;
      int   expFill;
      if (compareOn) begin
         expTx   = expectedTx();
         expFill = modelQ.size();
         checkCount++;
         if (tx === expTx && busy === modelActive && fifoEmpty === (expFill == 0) &&
             fifoFull === (expFill == DEPTH) && int'(fill) == expFill && overflow === modelOvf) begin
            passCount++;
         end else begin
            $display("[TB] FAIL cycleCompare cyc=%0d got tx=%b busy=%b empty=%b full=%b fill=%0d ovf=%b required tx=%b busy=%b empty=%b full=%b fill=%0d ovf=%b",
                     cyc, tx, busy, fifoEmpty, fifoFull, fill, overflow,
                     expTx, modelActive, (expFill == 0), (expFill == DEPTH), expFill, modelOvf);
         end
      end
   end

   task automatic checkOutput(input string name, input int actual, input int expected);
      checkCount++;
      if (actual == expected) passCount++;
      else $display("[TB] FAIL %s: got %0d, required %0d", name, actual, expected);
   endtask

   // Drives the inputs at a falling edge and holds them for one cycle.
   task automatic applyStimulus(input logic w, input logic [7:0] d, input logic c);
      wrEn   = w;
      wrData = d;
      ctsIn  = c;
      @(negedge clk);
   endtask

   task automatic waitDrained(input string name, input int limit);
      int n = 0;
      while ((busy || !fifoEmpty) && n < limit) begin
         @(negedge clk);
         n++;
      end
      checkOutput(name, (busy || !fifoEmpty) ? 1 : 0, 0);
   endtask

   task automatic waitTxLow(input int limit);
      int n = 0;
      while (tx && n < limit) begin
         @(negedge clk);
         n++;
      end
   endtask

   initial begin
      int         c0;
      int         s1;
      int         s2;
      int         n;
      logic       prevTx;
      logic [8:0] seen;

      reset  = 1'b1;
      wrEn   = 1'b0;
      wrData = '0;
      ctsIn  = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("resetTx", tx, 1);
      checkOutput("resetBusy", busy, 0);
      checkOutput("resetEmpty", fifoEmpty, 1);
      checkOutput("resetFill", fill, 0);
      checkOutput("resetOverflow", overflow, 0);
      reset = 1'b0;
      applyStimulus(1'b0, 8'h00, 1'b1);

      // Single byte 0xA5: latency, line pattern and frame length.
      c0 = cyc;
      applyStimulus(1'b1, 8'hA5, 1'b1);
      wrEn = 1'b0;
      waitTxLow(20);
      checkOutput("writeToStartLatency", cyc - c0, 3);
      s1 = cyc;
      for (int b = 0; b < 9; b++) begin
         seen[b] = tx;
         repeat (CD) @(negedge clk);
      end
      checkOutput("lineA5", int'(seen), 9'h14A);
`ifdef SAMPLE_UART_TX_PARITY_EN
      checkOutput("parityA5", tx, 0);
`else
      checkOutput("stopA5", tx, 1);
`endif
      n = 0;
      while (busy && n < 40) begin
         @(negedge clk);
         n++;
      end
      checkOutput("frameLength", cyc - s1, FRAME_LEN);

`ifdef SAMPLE_UART_TX_PARITY_EN
      // 0x07 has three ones, so even parity drives a 1.
      applyStimulus(1'b1, 8'h07, 1'b1);
      wrEn = 1'b0;
      waitTxLow(20);
      repeat (CD * 9) @(negedge clk);
      checkOutput("parity07", tx, 1);
      waitDrained("drain07", 100);
`endif

      // Back-to-back 0x00 then 0xFF.
      applyStimulus(1'b1, 8'h00, 1'b1);
      applyStimulus(1'b1, 8'hFF, 1'b1);
      wrEn = 1'b0;
      waitTxLow(20);
      s1 = cyc;
      n  = 0;
      do begin
         prevTx = tx;
         @(negedge clk);
         n++;
      end while (!(prevTx && !tx) && n < 100);
      s2 = cyc;
      checkOutput("startToStart", s2 - s1, FRAME_LEN + 2);
      checkOutput("emptyAfterSecondLoad", fifoEmpty, 1);
      waitDrained("drainBackToBack", 100);

      // cts low holds frames back; dropping it mid-frame stops after it.
      ctsIn = 1'b0;
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 8'($urandom), 1'b0);
      wrEn = 1'b0;
      repeat (5) @(negedge clk);
      checkOutput("ctsLowTx", tx, 1);
      checkOutput("ctsLowFill", fill, 3);
      ctsIn = 1'b1;
      n = 0;
      while (!busy && n < 10) begin
         @(negedge clk);
         n++;
      end
      checkOutput("ctsRaisedBusy", busy, 1);
      repeat (5) @(negedge clk);
      ctsIn = 1'b0;
      repeat (FRAME_LEN + 10) @(negedge clk);
      checkOutput("ctsDropBusy", busy, 0);
      checkOutput("ctsDropFill", fill, 2);
      ctsIn = 1'b1;
      waitDrained("drainCts", 200);

      // Overflow: fifth write is dropped and never sent.
      ctsIn = 1'b0;
      for (int i = 0; i < 5; i++) applyStimulus(1'b1, 8'($urandom), 1'b0);
      wrEn = 1'b0;
      @(negedge clk);
      checkOutput("overflowFill", fill, 4);
      checkOutput("overflowFull", fifoFull, 1);
      checkOutput("overflowFlag", overflow, 1);
      ctsIn = 1'b1;
      waitDrained("drainOverflow", 300);

      // Reset in the middle of 0x3C with two samples queued behind it.
      ctsIn = 1'b0;
      applyStimulus(1'b1, 8'h3C, 1'b0);
      applyStimulus(1'b1, 8'($urandom), 1'b0);
      applyStimulus(1'b1, 8'($urandom), 1'b0);
      wrEn  = 1'b0;
      ctsIn = 1'b1;
      n = 0;
      while (!busy && n < 10) begin
         @(negedge clk);
         n++;
      end
      repeat (10) @(negedge clk);
      checkOutput("fillBeforeReset", fill, 2);
      reset = 1'b1;
      @(negedge clk);
      checkOutput("midResetTx", tx, 1);
      checkOutput("midResetBusy", busy, 0);
      checkOutput("midResetFill", fill, 0);
      checkOutput("midResetOverflow", overflow, 0);
      reset = 1'b0;
      repeat (FRAME_LEN + 10) @(negedge clk);
      checkOutput("afterResetBusy", busy, 0);

      // Randomized writes with cts toggling, checked by the model.
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 49) == 0) ctsIn = ~ctsIn;
         applyStimulus(($urandom_range(0, 3) == 0), 8'($urandom), ctsIn);
      end
      wrEn  = 1'b0;
      ctsIn = 1'b1;
      waitDrained("drainRandom", 400);

      @(posedge clk);
      compareOn = 1'b0;
      #1;
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
